intersection_scheduler: RTL and testbench

Actuated two-approach intersection controller that sequences north-south (NS) and east-west (EW) signal heads, with all-red clearance between phases and an optional pedestrian walk phase. It arbitrates green time between the two vehicle approaches from presence sensors, and drives per-approach red/yellow/green lamp outputs plus an elapsed-time monitor. It sits above the single-head traffic light datapath and supplies its phase sequencing.

---
 rtl/intersection_scheduler_if.sv | 33 +++
 rtl/intersection_scheduler.sv | 141 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/intersection_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : intersection_scheduler_if
// Brief  : Vehicle/pedestrian requests and lamp outputs of the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface intersection_scheduler_if;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_pending;
    logic [7:0] phase_timer;

    modport master (
        output ns_req, ew_req, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  walk, ped_pending, phase_timer
    );

    modport slave (
        input  ns_req, ew_req, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output walk, ped_pending, phase_timer
    );
endinterface
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module : intersection_scheduler
// Brief  : Actuated NS/EW intersection phase sequencer with all-red clearance
//          and optional pedestrian walk phase (macro INTERSECTION_PED_EN).
// Rev    : 1.0  initial release
// ============================================================================
module intersection_scheduler #(
    parameter int unsigned GREEN_MIN = 10,
    parameter int unsigned GREEN_MAX = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    intersection_scheduler_if.slave  bus
);

    localparam logic [7:0] c_green_min_last = 8'(GREEN_MIN - 1);
    localparam logic [7:0] c_green_max_last = 8'(GREEN_MAX - 1);
    localparam logic [7:0] c_yellow_last    = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_allred_last    = 8'(ALLRED_T - 1);
    localparam logic [7:0] c_walk_last      = 8'(WALK_T - 1);

    typedef enum logic [2:0] {
        ST_ALLRED    = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_PED_WALK  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timer;
    logic       r_next_dir;
    logic       w_next_dir_next;
    logic       w_ped_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ALLRED;
            r_next_dir <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_next_dir <= w_next_dir_next;
        end
    end

    // Elapsed cycles in the current state; restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= 8'd0;
        end else if (w_state_next != r_state) begin
            r_timer <= 8'd0;
        end else if (r_timer != 8'hFF) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_next_dir_next = r_next_dir;
        case (r_state)
            ST_ALLRED: begin
                if (r_timer == c_allred_last) begin
                    if (w_ped_pending)   w_state_next = ST_PED_WALK;
                    else if (r_next_dir) w_state_next = ST_EW_GREEN;
                    else                 w_state_next = ST_NS_GREEN;
                end
            end
            ST_NS_GREEN: begin
                if ((r_timer >= c_green_min_last) &&
                    (bus.ew_req || w_ped_pending) &&
                    (!bus.ns_req || (r_timer >= c_green_max_last)))
                    w_state_next = ST_NS_YELLOW;
            end
            ST_NS_YELLOW: begin
                if (r_timer == c_yellow_last) begin
                    w_state_next    = ST_ALLRED;
                    w_next_dir_next = 1'b1;
                end
            end
            ST_EW_GREEN: begin
                if ((r_timer >= c_green_min_last) &&
                    (bus.ns_req || w_ped_pending) &&
                    (!bus.ew_req || (r_timer >= c_green_max_last)))
                    w_state_next = ST_EW_YELLOW;
            end
            ST_EW_YELLOW: begin
                if (r_timer == c_yellow_last) begin
                    w_state_next    = ST_ALLRED;
                    w_next_dir_next = 1'b0;
                end
            end
            // Walk returns to all-red with next_dir untouched, resuming rotation.
            ST_PED_WALK: begin
                if (r_timer == c_walk_last)
                    w_state_next = ST_ALLRED;
            end
            default: w_state_next = ST_ALLRED;
        endcase
    end

`ifdef INTERSECTION_PED_EN
    logic r_ped_pending;
    logic w_ped_clear;

    assign w_ped_clear = (w_state_next == ST_PED_WALK) && (r_state != ST_PED_WALK);

    // A new press wins over the clear on the edge that enters the walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_ped_pending <= 1'b0;
        else if (bus.ped_req)  r_ped_pending <= 1'b1;
        else if (w_ped_clear)  r_ped_pending <= 1'b0;
    end

    assign w_ped_pending   = r_ped_pending;
    assign bus.ped_pending = r_ped_pending;
    assign bus.walk        = (r_state == ST_PED_WALK);
`else
    logic w_unused_ped_req;

    assign w_unused_ped_req = bus.ped_req;
    assign w_ped_pending    = 1'b0;
    assign bus.ped_pending  = 1'b0;
    assign bus.walk         = 1'b0;
`endif

    assign bus.ns_green    = (r_state == ST_NS_GREEN);
    assign bus.ns_yellow   = (r_state == ST_NS_YELLOW);
    assign bus.ns_red      = !((r_state == ST_NS_GREEN) || (r_state == ST_NS_YELLOW));
    assign bus.ew_green    = (r_state == ST_EW_GREEN);
    assign bus.ew_yellow   = (r_state == ST_EW_YELLOW);
    assign bus.ew_red      = !((r_state == ST_EW_GREEN) || (r_state == ST_EW_YELLOW));
    assign bus.phase_timer = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_intersection_scheduler
// Brief  : Directed self-checking bench for intersection_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_intersection_scheduler;

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
    localparam logic [7:0] c_l_allred = 8'b0_100_100_0;
    localparam logic [7:0] c_l_nsg    = 8'b0_001_100_0;
    localparam logic [7:0] c_l_nsy    = 8'b0_010_100_0;
    localparam logic [7:0] c_l_ewg    = 8'b0_100_001_0;
    localparam logic [7:0] c_l_ewy    = 8'b0_100_010_0;
    localparam logic [7:0] c_l_walk   = 8'b0_100_100_1;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    intersection_scheduler_if bus ();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lamps();
        return {1'b0, bus.ns_red, bus.ns_yellow, bus.ns_green,
                bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        bus.ns_req  = 1'b1;
        bus.ew_req  = 1'b0;
        bus.ped_req = 1'b0;

        // Reset state and first green after release
        tick(2);
        check("rst_lamps", lamps(), c_l_allred);
        check("rst_timer", bus.phase_timer, 8'd0);
        check("rst_ped", {7'd0, bus.ped_pending}, 8'd0);
        rst = 1'b0;
        tick(1);
        check("rel1_lamps", lamps(), c_l_allred);
        check("rel1_timer", bus.phase_timer, 8'd1);
        tick(1);
        check("rel2_nsg", lamps(), c_l_nsg);
        check("rel2_timer", bus.phase_timer, 8'd0);
        tick(300);
        check("rest_nsg", lamps(), c_l_nsg);
        check("rest_sat", bus.phase_timer, 8'd255);

        // Minimum green with opposing demand only
        rst = 1'b1;
        #1;
        check("async_rst", lamps(), c_l_allred);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t2_nsg0", lamps(), c_l_nsg);
        bus.ns_req = 1'b0;
        bus.ew_req = 1'b1;
        tick(9);
        check("t2_nsg9", lamps(), c_l_nsg);
        check("t2_timer9", bus.phase_timer, 8'd9);
        tick(1);
        check("t2_nsy", lamps(), c_l_nsy);
        tick(2);
        check("t2_nsy2", lamps(), c_l_nsy);
        tick(1);
        check("t2_ar0", lamps(), c_l_allred);
        tick(1);
        check("t2_ar1", lamps(), c_l_allred);
        tick(1);
        check("t2_ewg", lamps(), c_l_ewg);

        // Maximum green with both approaches requesting
        rst        = 1'b1;
        bus.ns_req = 1'b1;
        bus.ew_req = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t3_nsg0", lamps(), c_l_nsg);
        tick(29);
        check("t3_nsg29", lamps(), c_l_nsg);
        check("t3_timer29", bus.phase_timer, 8'd29);
        tick(1);
        check("t3_nsy", lamps(), c_l_nsy);
        tick(3);
        check("t3_ar", lamps(), c_l_allred);
        tick(2);
        check("t3_ewg", lamps(), c_l_ewg);
        check("t3_ewg_t0", bus.phase_timer, 8'd0);

`ifdef INTERSECTION_PED_EN
        // Pedestrian request served between EW and NS greens
        bus.ns_req  = 1'b0;
        bus.ew_req  = 1'b0;
        bus.ped_req = 1'b1;
        tick(1);
        check("p_latch", {7'd0, bus.ped_pending}, 8'd1);
        bus.ped_req = 1'b0;
        tick(8);
        check("p_ewg9", lamps(), c_l_ewg);
        tick(1);
        check("p_ewy", lamps(), c_l_ewy);
        tick(3);
        check("p_ar", lamps(), c_l_allred);
        check("p_hold", {7'd0, bus.ped_pending}, 8'd1);
        tick(2);
        check("p_walk0", lamps(), c_l_walk);
        check("p_clear", {7'd0, bus.ped_pending}, 8'd0);
        tick(7);
        check("p_walk7", lamps(), c_l_walk);
        tick(1);
        check("p_ar2", lamps(), c_l_allred);
        tick(2);
        check("p_nsg", lamps(), c_l_nsg);
        check("p_end_ped", {7'd0, bus.ped_pending}, 8'd0);
`else
        // Pedestrian input ignored; sequence follows vehicle demand alone
        bus.ns_req = 1'b1;
        bus.ew_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ped_req = 1'($urandom_range(0, 1));
            tick(1);
            check("np_quiet", {6'd0, bus.walk, bus.ped_pending}, 8'd0);
        end
        bus.ped_req = 1'b0;
        check("np_ewy", lamps(), c_l_ewy);
        tick(3);
        check("np_ar", lamps(), c_l_allred);
        tick(2);
        check("np_nsg", lamps(), c_l_nsg);
`endif

        // Reset in the middle of NS yellow
        bus.ns_req = 1'b0;
        bus.ew_req = 1'b1;
        tick(11);
        check("r_nsy1", lamps(), c_l_nsy);
        check("r_nsy_t1", bus.phase_timer, 8'd1);
        rst = 1'b1;
        #1;
        check("r_async", lamps(), c_l_allred);
        check("r_timer", bus.phase_timer, 8'd0);
        tick(1);
        rst        = 1'b0;
        bus.ns_req = 1'b1;
        bus.ew_req = 1'b0;
        tick(1);
        check("r_rel1", lamps(), c_l_allred);
        tick(1);
        check("r_rel2", lamps(), c_l_nsg);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
